ldpc_ber_tester_dec_model: RTL



---
 rtl/ldpc_ber_tester_dec_model_pkg.sv | 32 +++
 rtl/ldpc_ber_tester_hard_slicer.sv | 27 ++
 rtl/ldpc_ber_tester_dec_model.sv | 153 +++++++++++++++
 3 files changed

// File: rtl/ldpc_ber_tester_dec_model_pkg.sv
// Shared definitions for the hard-decision decoder stand-in.
// Holds bus width defaults, CTRL/STATUS field offsets and the FSM state type.
// Also provides a saturating 16-bit add used for the ones counter.
package ldpc_ber_tester_dec_model_pkg;

  localparam int DEF_LLR_W  = 8;
  localparam int DEF_DIN_W  = 128;
  localparam int DEF_DOUT_W = 128;

  // CTRL word fields
  localparam int CTRL_BEATS_LSB = 0;
  localparam int CTRL_ID_LSB    = 16;

  // STATUS word fields
  localparam int ST_ID_LSB      = 0;
  localparam int ST_ERR_LEN_BIT = 8;
  localparam int ST_ONES_LSB    = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_STAT  = 2'd3
  } state_e;

  function automatic logic [15:0] sat_add16(input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[16] ? 16'hFFFF : s[15:0];
  endfunction

endpackage

// File: rtl/ldpc_ber_tester_hard_slicer.sv
// Sign slicer: one hard bit per LLR (sign bit, so LLR 0 maps to 0) plus popcount.
// Purely combinational, zero latency.
// No flow control; the caller qualifies the result with its own handshake.
module ldpc_ber_tester_hard_slicer
  import ldpc_ber_tester_dec_model_pkg::*;
#(
  parameter int LLR_W = DEF_LLR_W,
  parameter int DIN_W = DEF_DIN_W,
  parameter int NL    = DIN_W / LLR_W,
  parameter int CW    = $clog2(NL + 1)
) (
  input  logic [DIN_W-1:0] din_i,
  output logic [NL-1:0]    bits_o,
  output logic [CW-1:0]    ones_o
);

  // Take the sign bit of every LLR and count how many are set
  always_comb begin
    bits_o = '0;
    ones_o = '0;
    for (int i = 0; i < NL; i++) begin
      bits_o[i] = din_i[LLR_W*i + LLR_W - 1];
      ones_o    = ones_o + CW'(bits_o[i]);
    end
  end

endmodule

// File: rtl/ldpc_ber_tester_dec_model.sv
// Hard-decision decoder model: CTRL + DIN LLR beats in, packed sign bits on DOUT, one STATUS per block.
// DOUT valid 1 cycle after the DIN beat that completes a word; STATUS follows the last DOUT handshake.
// DIN stalls only when a completing beat meets a full, non-draining DOUT register; one block in flight.
module ldpc_ber_tester_dec_model
  import ldpc_ber_tester_dec_model_pkg::*;
#(
  parameter int LLR_W  = DEF_LLR_W,
  parameter int DIN_W  = DEF_DIN_W,
  parameter int DOUT_W = DEF_DOUT_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       s_axis_ctrl_tdata,
  input  logic              s_axis_ctrl_tvalid,
  output logic              s_axis_ctrl_tready,
  input  logic [DIN_W-1:0]  s_axis_din_tdata,
  input  logic              s_axis_din_tvalid,
  output logic              s_axis_din_tready,
  input  logic              s_axis_din_tlast,
  output logic [DOUT_W-1:0] m_axis_dout_tdata,
  output logic              m_axis_dout_tvalid,
  input  logic              m_axis_dout_tready,
  output logic              m_axis_dout_tlast,
  output logic [31:0]       m_axis_status_tdata,
  output logic              m_axis_status_tvalid,
  input  logic              m_axis_status_tready
);

  localparam int NL = DIN_W / LLR_W;
  localparam int PK = DOUT_W / NL;
  localparam int PW = (PK > 1) ? $clog2(PK) : 1;
  localparam int CW = $clog2(NL + 1);

  state_e            state_q;
  logic [15:0]       beats_q, beat_cnt_q, ones_q, ones_d;
  logic [7:0]        id_q;
  logic [PW-1:0]     pack_idx_q;
  logic [DOUT_W-1:0] pack_q, dout_q, word_d;
  logic              dout_vld_q, dout_last_q, err_len_q, status_vld_q;
  logic [31:0]       status_q, status_d;
  logic [NL-1:0]     slice_bits;
  logic [CW-1:0]     slice_ones;
  logic [15:0]       ctrl_beats;
  logic              cnt_hit, blk_end, word_done, dout_busy, din_rdy, din_acc;
  logic              unused_ctrl;

  ldpc_ber_tester_hard_slicer #(
    .LLR_W (LLR_W),
    .DIN_W (DIN_W)
  ) u_slicer (
    .din_i  (s_axis_din_tdata),
    .bits_o (slice_bits),
    .ones_o (slice_ones)
  );

  assign unused_ctrl = ^s_axis_ctrl_tdata[31:24];

  // Block-end detection, DIN stall decision and the next packed word
  always_comb begin
    ctrl_beats = s_axis_ctrl_tdata[CTRL_BEATS_LSB +: 16];
    cnt_hit    = (beat_cnt_q + 16'd1) == beats_q;
    blk_end    = cnt_hit | s_axis_din_tlast;
    word_done  = (pack_idx_q == PW'(PK - 1)) | blk_end;
    dout_busy  = dout_vld_q & ~m_axis_dout_tready;
    din_rdy    = (state_q == S_RUN) & ~reset & ~(dout_busy & word_done);
    din_acc    = din_rdy & s_axis_din_tvalid;
    word_d     = pack_q | (DOUT_W'(slice_bits) << (NL * int'(pack_idx_q)));
    ones_d     = sat_add16(ones_q, 16'(slice_ones));
    status_d   = '0;
    status_d[ST_ONES_LSB +: 16] = ones_q;
    status_d[ST_ERR_LEN_BIT]    = err_len_q;
    status_d[ST_ID_LSB +: 8]    = id_q;
  end

  assign s_axis_ctrl_tready   = (state_q == S_IDLE) & ~reset;
  assign s_axis_din_tready    = din_rdy;
  assign m_axis_dout_tdata    = dout_q;
  assign m_axis_dout_tvalid   = dout_vld_q;
  assign m_axis_dout_tlast    = dout_last_q;
  assign m_axis_status_tdata  = status_q;
  assign m_axis_status_tvalid = status_vld_q;

  // Block FSM with the DOUT output register and STATUS register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      beats_q      <= '0;
      beat_cnt_q   <= '0;
      ones_q       <= '0;
      id_q         <= '0;
      pack_idx_q   <= '0;
      pack_q       <= '0;
      dout_q       <= '0;
      dout_vld_q   <= 1'b0;
      dout_last_q  <= 1'b0;
      err_len_q    <= 1'b0;
      status_vld_q <= 1'b0;
      status_q     <= '0;
    end else begin
      if (dout_vld_q && m_axis_dout_tready) dout_vld_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (s_axis_ctrl_tvalid) begin
            beats_q    <= (ctrl_beats == 16'd0) ? 16'd1 : ctrl_beats;
            id_q       <= s_axis_ctrl_tdata[CTRL_ID_LSB +: 8];
            beat_cnt_q <= '0;
            pack_idx_q <= '0;
            pack_q     <= '0;
            ones_q     <= '0;
            err_len_q  <= 1'b0;
            state_q    <= S_RUN;
          end
        end
        S_RUN: begin
          if (din_acc) begin
            beat_cnt_q <= beat_cnt_q + 16'd1;
            ones_q     <= ones_d;
            if (word_done) begin
              dout_q      <= word_d;
              dout_vld_q  <= 1'b1;
              dout_last_q <= blk_end;
              pack_q      <= '0;
              pack_idx_q  <= '0;
            end else begin
              pack_q      <= word_d;
              pack_idx_q  <= pack_idx_q + PW'(1);
            end
            if (blk_end) begin
              err_len_q <= s_axis_din_tlast ^ cnt_hit;
              state_q   <= S_DRAIN;
            end
          end
        end
        S_DRAIN: begin
          if (dout_vld_q && dout_last_q && m_axis_dout_tready) begin
            dout_last_q  <= 1'b0;
            status_q     <= status_d;
            status_vld_q <= 1'b1;
            state_q      <= S_STAT;
          end
        end
        S_STAT: begin
          if (m_axis_status_tready) begin
            status_vld_q <= 1'b0;
            state_q      <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

endmodule
